// File: rtl/mlp_sequencer.sv
// Sequences one two-layer MLP inference: fetches bias/weight words from flash, stages input
// lanes, drives the accumulate ALU and writes each activated neuron into activation memory.
module mlp_sequencer #(
   parameter int LANES     = 4,
   parameter int DW        = 4,
   parameter int L1_IN     = 144,
   parameter int L1_NEUR   = 8,
   parameter int L2_NEUR   = 10,
   parameter int ADDR_W    = 16,
   parameter int BASE_ADDR = 0,
   parameter int ALU_LAT   = 2,
   parameter int AW        = 5
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  in_rd_en,
   output logic [((L1_IN/LANES > 1) ? $clog2(L1_IN/LANES) : 1)-1:0] in_idx,
   input  logic [LANES*DW-1:0]   in_data,
   output logic                  flash_req,
   output logic [ADDR_W-1:0]     flash_addr,
   input  logic                  flash_valid,
   input  logic [LANES*DW-1:0]   flash_data,
   output logic [AW-1:0]         act_raddr,
   input  logic [DW-1:0]         act_rdata,
   output logic                  act_wr_en,
   output logic [AW-1:0]         act_waddr,
   output logic [DW-1:0]         act_wdata,
   output logic                  alu_clear,
   output logic                  alu_acc,
   output logic [DW-1:0]         alu_bias,
   output logic [LANES*DW-1:0]   alu_weight,
   output logic [LANES*DW-1:0]   alu_input,
   input  logic [DW-1:0]         alu_result
);

   localparam int G1    = L1_IN / LANES;
   localparam int G2    = L1_NEUR / LANES;
   localparam int IDX_W = (G1 > 1) ? $clog2(G1) : 1;
   localparam int GMAX  = (G1 > G2) ? G1 : G2;
   localparam int GW    = $clog2(GMAX + 1);
   localparam int NMAX  = (L1_NEUR > L2_NEUR) ? L1_NEUR : L2_NEUR;
   localparam int NW    = $clog2(NMAX + 1);
   localparam int KW    = $clog2(LANES + 1);
   localparam int DCW   = $clog2(ALU_LAT + 1);

   if ((L1_IN % LANES) != 0 || (L1_NEUR % LANES) != 0 || (L1_NEUR + L2_NEUR) > (1 << AW))
   begin : g_param_check
      $error("mlp_sequencer: L1_IN/L1_NEUR must be multiples of LANES and all neurons must fit in 2^AW");
   end

   typedef enum logic [3:0] {
      IDLE, BIAS_REQ, W_REQ, IN_LOAD, ACC, DRAIN, WRITE, NEXT, FINISH
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic              layer;
   logic [NW-1:0]     neuron;
   logic [GW-1:0]     group;
   logic [KW-1:0]     k;
   logic [DCW-1:0]    dcnt;
   logic              grp_last, neur_last, lane_done, drain_done;

   assign flash_addr = ptr;
   assign busy       = (state != IDLE) && (state != FINISH);
   assign grp_last   = layer ? (group == GW'(G2 - 1)) : (group == GW'(G1 - 1));
   assign neur_last  = layer ? (neuron == NW'(L2_NEUR - 1)) : (neuron == NW'(L1_NEUR - 1));
   assign lane_done  = (k == KW'(LANES));
   assign drain_done = (dcnt == DCW'(ALU_LAT - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      flash_req = 1'b0;
      in_rd_en  = 1'b0;
      in_idx    = '0;
      act_raddr = '0;
      act_wr_en = 1'b0;
      act_waddr = '0;
      act_wdata = '0;
      alu_acc   = 1'b0;
      case (state)
         IDLE:     if (start) state_nxt = BIAS_REQ;
         BIAS_REQ: begin
            flash_req = 1'b1;
            if (flash_valid) state_nxt = W_REQ;
         end
         W_REQ: begin
            flash_req = 1'b1;
            if (flash_valid) state_nxt = IN_LOAD;
         end
         IN_LOAD: begin
            if (!layer) begin
               in_rd_en  = 1'b1;
               in_idx    = IDX_W'(group);
               state_nxt = ACC;
            end else if (!lane_done) begin
               act_raddr = AW'(group) * AW'(LANES) + AW'(k);
            end else begin
               state_nxt = ACC;
            end
         end
         ACC: begin
            alu_acc   = 1'b1;
            state_nxt = grp_last ? DRAIN : W_REQ;
         end
         DRAIN:    if (drain_done) state_nxt = WRITE;
         WRITE: begin
            act_wr_en = 1'b1;
            act_waddr = layer ? AW'(L1_NEUR) + AW'(neuron) : AW'(neuron);
            act_wdata = alu_result;
            state_nxt = NEXT;
         end
         NEXT:     state_nxt = (layer && neur_last) ? FINISH : BIAS_REQ;
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ptr        <= ADDR_W'(BASE_ADDR);
         layer      <= 1'b0;
         neuron     <= '0;
         group      <= '0;
         k          <= '0;
         dcnt       <= '0;
         alu_clear  <= 1'b0;
         alu_bias   <= '0;
         alu_weight <= '0;
         alu_input  <= '0;
      end else begin
         alu_clear <= 1'b0;
         case (state)
            IDLE: if (start) begin
               ptr    <= ADDR_W'(BASE_ADDR);
               layer  <= 1'b0;
               neuron <= '0;
               group  <= '0;
            end
            BIAS_REQ: if (flash_valid) begin
               alu_bias  <= flash_data[DW-1:0];
               alu_clear <= 1'b1;
               ptr       <= ptr + ADDR_W'(1);
               group     <= '0;
            end
            W_REQ: if (flash_valid) begin
               alu_weight <= flash_data;
               ptr        <= ptr + ADDR_W'(1);
               k          <= '0;
            end
            IN_LOAD: begin
               if (!layer) begin
                  alu_input <= in_data;
               end else begin
                  // Read data lags the address by one cycle, so lane i lands on step i+1.
                  for (int i = 0; i < LANES; i++)
                     if (k == KW'(i + 1)) alu_input[i*DW +: DW] <= act_rdata;
                  if (!lane_done) k <= k + KW'(1);
               end
            end
            ACC: begin
               group <= group + GW'(1);
               dcnt  <= '0;
            end
            DRAIN: if (!drain_done) dcnt <= dcnt + DCW'(1);
            NEXT: begin
               if (neur_last) begin
                  neuron <= '0;
                  layer  <= 1'b1;
               end else begin
                  neuron <= neuron + NW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer: flash/input/activation/ALU models around the DUT, scenario table
// of full inferences with hand-computed writes, plus a mid-inference reset sequence.
module tb_mlp_sequencer;
   localparam int LANES = 4, DW = 4, L1_IN = 8, L1_NEUR = 4, L2_NEUR = 2;
   localparam int ADDR_W = 16, BASE = 'h10, ALU_LAT = 2, AW = 5;

   logic                clk;
   logic                n_rst = 1'b0;
   logic                start = 1'b0;
   logic                busy, done, in_rd_en, flash_req, act_wr_en, alu_clear, alu_acc;
   logic [0:0]          in_idx;
   logic [15:0]         in_data, flash_addr, flash_data, alu_weight, alu_input;
   logic                flash_valid;
   logic [AW-1:0]       act_raddr, act_waddr;
   logic [DW-1:0]       act_rdata, act_wdata, alu_bias;
   logic [DW-1:0]       alu_result = '0;

   mlp_sequencer #(
      .LANES(LANES), .DW(DW), .L1_IN(L1_IN), .L1_NEUR(L1_NEUR), .L2_NEUR(L2_NEUR),
      .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ALU_LAT(ALU_LAT), .AW(AW)
   ) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .busy(busy), .done(done),
      .in_rd_en(in_rd_en), .in_idx(in_idx), .in_data(in_data),
      .flash_req(flash_req), .flash_addr(flash_addr), .flash_valid(flash_valid),
      .flash_data(flash_data), .act_raddr(act_raddr), .act_rdata(act_rdata),
      .act_wr_en(act_wr_en), .act_waddr(act_waddr), .act_wdata(act_wdata),
      .alu_clear(alu_clear), .alu_acc(alu_acc), .alu_bias(alu_bias),
      .alu_weight(alu_weight), .alu_input(alu_input), .alu_result(alu_result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Flash image: L1 neurons (bias, w0, w1) x4 then L2 neurons (bias, w) x2.
   logic [15:0] fmem [16] = '{16'h0001, 16'h0001, 16'h0000,
                              16'hABC0, 16'h0030, 16'h0000,
                              16'h0002, 16'h0000, 16'h0200,
                              16'h5550, 16'h5512, 16'h4100,
                              16'h0001, 16'h0011,
                              16'h0000, 16'h2100};
   logic [15:0] in_mem [2] = '{16'h0021, 16'h1300};
   logic [3:0]  act_mem [32];
   assign in_data = in_mem[in_idx];

   function automatic int dot(input logic [15:0] w, input logic [15:0] x);
      int s = 0;
      for (int i = 0; i < LANES; i++) s += int'(w[i*4 +: 4]) * int'(x[i*4 +: 4]);
      return s;
   endfunction

   // ALU with a two-stage result pipe, and the activation RAM with one-cycle read latency.
   int         acc_m = 0;
   logic [3:0] d1 = '0;
   initial for (int i = 0; i < 32; i++) act_mem[i] = '0;
   always @(posedge clk) begin
      if (alu_clear)    acc_m <= int'(alu_bias);
      else if (alu_acc) acc_m <= acc_m + dot(alu_weight, alu_input);
      d1         <= acc_m[3:0];
      alu_result <= d1;
      act_rdata  <= act_mem[act_raddr];
      if (act_wr_en) act_mem[act_waddr] <= act_wdata;
   end

   // Flash responder: valid after slow_delay request cycles at slow_addr, else after one.
   int slow_addr = 'h12, slow_delay = 1, rcnt = 0, spur_tick = 0;
   bit spur_en = 1'b0;
   initial begin
      flash_valid = 1'b0;
      flash_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (flash_valid) begin
            flash_valid = 1'b0;
            rcnt        = 0;
         end
         if (flash_req) begin
            rcnt++;
            if (rcnt > ((int'(flash_addr) == slow_addr) ? slow_delay : 1)) begin
               flash_valid = 1'b1;
               flash_data  = (int'(flash_addr) >= BASE && int'(flash_addr) < BASE + 16)
                             ? fmem[int'(flash_addr) - BASE] : 16'hDEAD;
            end
         end else begin
            rcnt = 0;
            if (spur_en && (spur_tick++ % 3 == 0)) begin
               flash_valid = 1'b1;
               flash_data  = 16'hFFFF;
            end
         end
      end
   end

   int          n_words = 0, n_writes = 0, n_acc = 0, n_clear = 0, n_done = 0;
   int          n_slow = 0, n_acc_wait = 0;
   bit          wait_open = 1'b0;
   logic [15:0] word_log [256];
   logic [4:0]  wa_log [64];
   logic [3:0]  wd_log [64];
   logic [15:0] ain_log [64], aw_log [64], rh_log [64];
   logic [4:0]  rh [5] = '{default: '0};

   always @(negedge clk) begin
      if (flash_req && !flash_valid) begin
         wait_open = 1'b1;
         if (int'(flash_addr) == slow_addr) n_slow++;
      end
      if (flash_req && flash_valid) begin
         wait_open = 1'b0;
         if (n_words < 256) word_log[n_words] = flash_addr;
         n_words++;
      end
      if (alu_clear) n_clear++;
      if (alu_acc) begin
         if (wait_open) n_acc_wait++;
         ain_log[n_acc % 64] = alu_input;
         aw_log[n_acc % 64]  = alu_weight;
         rh_log[n_acc % 64]  = {rh[4][3:0], rh[3][3:0], rh[2][3:0], rh[1][3:0]};
         n_acc++;
      end
      if (act_wr_en) begin
         wa_log[n_writes % 64] = act_waddr;
         wd_log[n_writes % 64] = act_wdata;
         n_writes++;
      end
      if (done) n_done++;
      for (int i = 4; i > 0; i--) rh[i] = rh[i-1];
      rh[0] = act_raddr;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, int'({busy, done, in_rd_en, in_idx, flash_req, act_wr_en,
                                alu_clear, alu_acc}), 0);
      chk({tag, "_addr_data"}, int'({act_raddr, act_waddr, act_wdata, alu_bias}), 0);
      chk({tag, "_lanes"}, int'({alu_weight, alu_input}), 0);
      chk({tag, "_flash_addr"}, int'(flash_addr), BASE);
   endtask

   typedef struct {
      int slow_addr; int slow_delay; bit spur; bit extra_start;
      int exp_words; int exp_writes; int exp_acc; int exp_clear; int exp_done; int exp_slow;
   } scen_t;

   int exp_wd [6] = '{2, 6, 8, 11, 9, 14};

   task automatic run_scenario(input scen_t s, input int id);
      int  b_words = n_words, b_writes = n_writes, b_acc = n_acc, b_clear = n_clear;
      int  b_done = n_done, b_slow = n_slow, b_wait = n_acc_wait, bad = 0;
      bit  got_done = 1'b0;
      slow_addr  = s.slow_addr;
      slow_delay = s.slow_delay;
      spur_en    = s.spur;
      @(posedge clk); #1 start = 1'b1;
      @(negedge clk); chk($sformatf("s%0d_busy_before", id), int'(busy), 0);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); chk($sformatf("s%0d_busy_after_start", id), int'(busy), 1);
      for (int j = 0; j < 2000 && !got_done; j++) begin
         @(posedge clk); #1;
         start = s.extra_start && (j == 10 || j == 40 || j == 41);
         if (n_done > b_done) got_done = 1'b1;
      end
      start = 1'b0;
      chk($sformatf("s%0d_done_in_budget", id), int'(got_done), 1);
      repeat (10) @(posedge clk);
      spur_en = 1'b0;
      #1;
      chk($sformatf("s%0d_flash_words", id), n_words - b_words, s.exp_words);
      for (int i = 0; i < s.exp_words; i++)
         if (int'(word_log[(b_words + i) % 256]) != BASE + i) bad++;
      chk($sformatf("s%0d_flash_addr_order", id), bad, 0);
      chk($sformatf("s%0d_writes", id), n_writes - b_writes, s.exp_writes);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("s%0d_waddr%0d", id, i), int'(wa_log[(b_writes + i) % 64]), i);
         chk($sformatf("s%0d_wdata%0d", id, i), int'(wd_log[(b_writes + i) % 64]), exp_wd[i]);
      end
      chk($sformatf("s%0d_alu_acc", id), n_acc - b_acc, s.exp_acc);
      chk($sformatf("s%0d_alu_clear", id), n_clear - b_clear, s.exp_clear);
      chk($sformatf("s%0d_done", id), n_done - b_done, s.exp_done);
      chk($sformatf("s%0d_slow_wait", id), n_slow - b_slow, s.exp_slow);
      chk($sformatf("s%0d_acc_in_wait", id), n_acc_wait - b_wait, 0);
      chk($sformatf("s%0d_l2_input", id), int'(ain_log[(b_acc + 8) % 64]), 'hB862);
      chk($sformatf("s%0d_l2_weight", id), int'(aw_log[(b_acc + 8) % 64]), 'h0011);
      chk($sformatf("s%0d_l2_raddr_seq", id), int'(rh_log[(b_acc + 8) % 64]), 'h0123);
   endtask

   initial begin
      scen_t tbl [3];
      int    b_acc, b_words, b_writes, b_done;
      tbl[0] = '{'h12, 1, 1'b0, 1'b0, 16, 6, 10, 6, 1, 1};
      tbl[1] = '{'h12, 7, 1'b0, 1'b0, 16, 6, 10, 6, 1, 7};
      tbl[2] = '{'h12, 1, 1'b1, 1'b1, 16, 6, 10, 6, 1, 1};

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1 n_rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outputs("idle");

      for (int i = 0; i < 3; i++) run_scenario(tbl[i], i);

      // Abort during layer-2 drain, then a fresh start must replay the whole inference.
      b_acc = n_acc;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int j = 0; j < 500 && n_acc < b_acc + 9; j++) @(posedge clk);
      chk("abort_reached_l2_acc", n_acc - b_acc, 9);
      #1 n_rst = 1'b0;
      #1 chk_reset_outputs("mid_reset");
      b_words = n_words; b_writes = n_writes; b_done = n_done;
      repeat (3) @(negedge clk);
      chk_reset_outputs("held_reset");
      @(posedge clk); #1 n_rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_abort_flash_words", n_words - b_words, 0);
      chk("post_abort_writes", n_writes - b_writes, 0);
      chk("post_abort_done", n_done - b_done, 0);
      run_scenario(tbl[0], 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
